mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one shared memory port between instruction fetch and data access.
// Optional MEM_ARBITER_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES cycles without mem_ready.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_read_en,
  input  logic        dm_write_en,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        cpu_stall,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;
  state_t r_state;
  logic   r_fetch_owed;
  logic   w_dm_req, w_grant_fetch, w_abort;
  assign w_dm_req      = dm_read_en | dm_write_en;
  // a fetch that waited through a data access wins the next grant
  assign w_grant_fetch = if_req & (r_fetch_owed | ~w_dm_req);
  assign cpu_stall     = (if_req | w_dm_req) & ~(if_ack | dm_ack);
`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tcnt;
  assign w_abort = ~mem_ready & (r_tcnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (!rst || r_state == IDLE || r_state == RESP) r_tcnt <= '0;
    else if (!mem_ready) r_tcnt <= r_tcnt + CW'(1);
  end
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_fetch_owed <= 1'b0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      if_ack       <= 1'b0;
      dm_ack       <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      err          <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_fetch) begin
            r_state      <= FETCH;
            r_fetch_owed <= 1'b0;
            mem_addr     <= if_addr;
            mem_re       <= 1'b1;
          end else if (w_dm_req) begin
            r_state      <= DATA;
            r_fetch_owed <= 1'b0;
            mem_addr     <= dm_addr;
            mem_wdata    <= dm_wdata;
            mem_we       <= dm_write_en;
            mem_re       <= ~dm_write_en;
          end
        end
        FETCH, DATA: begin
          if (r_state == DATA && if_req) r_fetch_owed <= 1'b1;
          if (mem_ready || w_abort) begin
            r_state <= RESP;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            err     <= ~mem_ready;
`endif
            if (r_state == FETCH) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '1;
            end else begin
              dm_ack <= 1'b1;
              if (mem_re) dm_rdata <= mem_ready ? mem_rdata : '1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          if_ack  <= 1'b0;
          dm_ack  <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
          err     <= 1'b0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int TO = 4;
`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic        clk = 0, rst = 0;
  logic        if_req = 0, dm_read_en = 0, dm_write_en = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_re, mem_we, cpu_stall, err;
  always #5 clk = ~clk;
  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_read_en(dm_read_en), .dm_write_en(dm_write_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cpu_stall(cpu_stall), .err(err)
  );
  int n_cmp = 0, n_bad = 0;
  bit en = 0;
  // model: one in-flight transaction record plus the response to show next cycle
  bit          m_busy = 0, m_fetch = 0, m_write = 0, m_resp = 0, m_owed = 0;
  bit          m_if_ack = 0, m_dm_ack = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_dm_rdata = 0;
  int          m_wait = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic start(input bit f, input bit w, input logic [31:0] a, input logic [31:0] d);
    m_busy = 1; m_fetch = f; m_write = w; m_addr = a; m_wdata = d; m_wait = 0; m_owed = 0;
  endtask
  task automatic model_edge();
    bit to;
    logic [31:0] d;
    if (!rst) begin
      m_busy = 0; m_resp = 0; m_owed = 0; m_if_ack = 0; m_dm_ack = 0; m_err = 0;
      m_if_rdata = 0; m_dm_rdata = 0;
    end else if (m_resp) begin
      m_resp = 0; m_if_ack = 0; m_dm_ack = 0; m_err = 0;
    end else if (m_busy) begin
      if (!m_fetch && if_req) m_owed = 1;
      if (!mem_ready) m_wait++;
      to = TO_EN && !mem_ready && m_wait == TO;
      if (mem_ready || to) begin
        d = to ? 32'hFFFF_FFFF : mem_rdata;
        if (m_fetch) begin m_if_rdata = d; m_if_ack = 1; end
        else begin if (!m_write) m_dm_rdata = d; m_dm_ack = 1; end
        m_err = to; m_busy = 0; m_resp = 1;
      end
    end else if (if_req && (m_owed || !(dm_read_en || dm_write_en))) start(1, 0, if_addr, 0);
    else if (dm_read_en || dm_write_en) start(0, dm_write_en, dm_addr, dm_wdata);
  endtask
  task automatic tick();
    #1;
    if (en) begin
      chk("mem_re", mem_re, m_busy && !m_write);
      chk("mem_we", mem_we, m_busy && m_write);
      chk("strobe_excl", mem_re & mem_we, 0);
      if (m_busy) chk("mem_addr", mem_addr, m_addr);
      if (m_busy && m_write) chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_ack", if_ack, m_if_ack);
      chk("dm_ack", dm_ack, m_dm_ack);
      chk("err", err, m_err);
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("dm_rdata", dm_rdata, m_dm_rdata);
      chk("cpu_stall", cpu_stall, (if_req | dm_read_en | dm_write_en) & ~(m_if_ack | m_dm_ack));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  task automatic drain();
    if_req = 0; dm_read_en = 0; dm_write_en = 0; mem_ready = 1;
    repeat (4) tick();
  endtask
  initial begin
    int first;
    bit got;
    @(negedge clk);
    rst = 0;
    repeat (2) tick();
    en = 1; rst = 1;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_re", mem_re, 0);
    tick();
    // single fetch, zero wait states
    if_req = 1; if_addr = 32'h10; mem_ready = 1; mem_rdata = 32'h00A00093;
    tick();
    chk("f_mem_re_n1", mem_re, 1);
    chk("f_addr_n1", mem_addr, 32'h10);
    chk("f_stall_n1", cpu_stall, 1);
    tick();
    chk("f_ack_n2", if_ack, 1);
    chk("f_rdata_n2", if_rdata, 32'h00A00093);
    chk("f_stall_n2", cpu_stall, 0);
    if_req = 0;
    tick();
    chk("f_ack_n3", if_ack, 0);
    drain();
    // simultaneous fetch and write: data first, then fetch
    if_req = 1; if_addr = 32'h20; dm_write_en = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
    mem_ready = 1; mem_rdata = 32'h13;
    tick();
    chk("w_we_n1", mem_we, 1);
    chk("w_re_n1", mem_re, 0);
    chk("w_addr_n1", mem_addr, 32'h100);
    chk("w_wdata_n1", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("w_dmack_n2", dm_ack, 1);
    dm_write_en = 0;
    repeat (2) tick();
    chk("w_fetch_re_n4", mem_re, 1);
    chk("w_fetch_addr_n4", mem_addr, 32'h20);
    tick();
    chk("w_ifack_n5", if_ack, 1);
    drain();
    // held data reads with a pending fetch alternate grants
    if_req = 1; if_addr = 32'h400; dm_read_en = 1; dm_addr = 32'h500; mem_ready = 1;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      mem_rdata = $urandom;
      tick();
      if (i == 3) chk("alt_fetch_addr", mem_addr, 32'h400);
      if (i == 6) chk("alt_data_addr", mem_addr, 32'h500);
      if (if_ack && first < 0) begin first = i + 1; if_req = 0; end
    end
    chk("alt_ifack_cycle", first, 5);
    drain();
    // five wait states on a data read
    dm_read_en = 1; dm_addr = 32'h200; mem_ready = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("ws_re", mem_re, 1);
      chk("ws_addr", mem_addr, 32'h200);
      tick();
    end
    mem_ready = 1; mem_rdata = 32'h12345678;
    chk("ws_re_n6", mem_re, 1);
    tick();
    chk("ws_ack_n7", dm_ack, 1);
    chk("ws_rdata_n7", dm_rdata, 32'h12345678);
    drain();
    // reset while waiting in DATA
    dm_read_en = 1; dm_addr = 32'h300; mem_ready = 0;
    repeat (2) tick();
    rst = 0;
    tick();
    chk("rs_re", mem_re, 0);
    chk("rs_ack", dm_ack, 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_dm_rdata", dm_rdata, 0);
    rst = 1;
    drain();
`ifdef MEM_ARBITER_TIMEOUT_EN
    dm_read_en = 1; dm_addr = 32'h600; mem_ready = 0; got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (dm_ack) begin
        got = 1;
        chk("to_err", err, 1);
        chk("to_rdata", dm_rdata, 32'hFFFF_FFFF);
        chk("to_cycle", i + 1, 5);
        dm_read_en = 0;
      end
    end
    chk("to_ack_seen", got, 1);
    drain();
`else
    got = 0;
`endif
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) != 0);
      if (m_if_ack || !if_req) begin
        if_req = ($urandom_range(0, 2) == 0); if_addr = $urandom;
      end else if (m_busy && m_fetch && $urandom_range(0, 15) == 0) if_req = 0;
      if (m_dm_ack || !(dm_read_en || dm_write_en)) begin
        if ($urandom_range(0, 2) == 0) begin
          dm_read_en = $urandom_range(0, 1);
          dm_write_en = dm_read_en ? ($urandom_range(0, 3) == 0) : 1'b1;
        end else begin
          dm_read_en = 0; dm_write_en = 0;
        end
        dm_addr = $urandom; dm_wdata = $urandom;
      end else if (m_busy && !m_fetch && $urandom_range(0, 15) == 0) begin
        dm_read_en = 0; dm_write_en = 0;
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      tick();
    end
    rst = 1;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
